pwm_generator: RTL

//  Three-channel PWM engine. Sits directly downstream of the SPI register manager and consumes its

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_generator_if.sv | 36 +++
 rtl/pwm_timebase.sv | 98 +++++++++
 rtl/pwm_generator.sv | 68 ++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared state encoding and default sizing for the PWM engine.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Timebase run state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_CH_DEF = 3;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_generator_if
// Description : Control/status bundle between the register manager (master)
//               and the PWM engine (slave). Names are from the engine's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_generator_if
  import pwm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) ();

  logic                     i_Enable;
  logic [DATA_W-1:0]        i_Period;
  logic [DATA_W-1:0]        i_Prescaler;
  logic [NUM_CH*DATA_W-1:0] i_Duty;
  logic [NUM_CH-1:0]        o_Pwm;
  logic                     o_Period_End;
  logic                     o_Running;

  // Register manager side: drives configuration, observes status
  modport master (
    output i_Enable, i_Period, i_Prescaler, i_Duty,
    input  o_Pwm, o_Period_End, o_Running
  );

  // PWM engine side
  modport slave (
    input  i_Enable, i_Period, i_Prescaler, i_Duty,
    output o_Pwm, o_Period_End, o_Running
  );

endinterface : pwm_generator_if
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : Run/idle FSM, prescaler, period counter and shadow registers.
//               Shadows load on entry to RUN and at every period wrap, so
//               configuration writes never disturb a period in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  wire logic                     i_Clk,
  input  wire logic                     i_Rst,
  input  wire logic                     i_Enable,
  input  wire logic [DATA_W-1:0]        i_Period,
  input  wire logic [DATA_W-1:0]        i_Prescaler,
  input  wire logic [NUM_CH*DATA_W-1:0] i_Duty,
  output logic      [DATA_W-1:0]        o_Count,
  output logic      [NUM_CH*DATA_W-1:0] o_Sh_Duty,
  output logic                          o_Run,
  output logic                          o_Period_End
);

  localparam logic [DATA_W-1:0] c_ZERO = '0;
  localparam logic [DATA_W-1:0] c_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t                    r_state;
  logic [DATA_W-1:0]         r_presc_cnt;
  logic [DATA_W-1:0]         r_count;
  logic [DATA_W-1:0]         r_sh_period;
  logic [DATA_W-1:0]         r_sh_presc;
  logic [NUM_CH*DATA_W-1:0]  r_sh_duty;
  logic                      r_period_end;

  // FSM, prescaler, period counter and shadow reloads in one registered block
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state      <= ST_IDLE;
      r_presc_cnt  <= c_ZERO;
      r_count      <= c_ZERO;
      r_sh_period  <= c_ZERO;
      r_sh_presc   <= c_ZERO;
      r_sh_duty    <= '0;
      r_period_end <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_presc_cnt  <= c_ZERO;
          r_count      <= c_ZERO;
          r_period_end <= 1'b0;
          if (i_Enable) begin
            r_sh_period <= i_Period;
            r_sh_presc  <= i_Prescaler;
            r_sh_duty   <= i_Duty;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!i_Enable) begin
            // Stop immediately; no drain to the end of the period
            r_state      <= ST_IDLE;
            r_presc_cnt  <= c_ZERO;
            r_count      <= c_ZERO;
            r_period_end <= 1'b0;
          end else begin
            r_period_end <= 1'b0;
            if (r_presc_cnt == r_sh_presc) begin
              r_presc_cnt <= c_ZERO;
              if (r_count == r_sh_period) begin
                // Period boundary: the only point new settings are adopted
                r_count      <= c_ZERO;
                r_sh_period  <= i_Period;
                r_sh_presc   <= i_Prescaler;
                r_sh_duty    <= i_Duty;
                r_period_end <= 1'b1;
              end else begin
                r_count <= r_count + c_ONE;
              end
            end else begin
              r_presc_cnt <= r_presc_cnt + c_ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_Count      = r_count;
  assign o_Sh_Duty    = r_sh_duty;
  assign o_Run        = (r_state == ST_RUN);
  assign o_Period_End = r_period_end;

endmodule : pwm_timebase
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module      : pwm_generator
// Description : Multi-channel PWM engine: shared timebase plus one registered
//               count-versus-duty comparator per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  wire logic      i_Clk,
  input  wire logic      i_Rst,
  pwm_generator_if.slave bus
);

  logic [DATA_W-1:0]        w_count;
  logic [NUM_CH*DATA_W-1:0] w_sh_duty;
  logic                     w_run;
  logic                     w_period_end;
  logic                     w_cmp_en;
  logic [NUM_CH-1:0]        w_pwm;

  pwm_timebase #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) u_timebase (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Enable     (bus.i_Enable),
    .i_Period     (bus.i_Period),
    .i_Prescaler  (bus.i_Prescaler),
    .i_Duty       (bus.i_Duty),
    .o_Count      (w_count),
    .o_Sh_Duty    (w_sh_duty),
    .o_Run        (w_run),
    .o_Period_End (w_period_end)
  );

  // Outputs are forced low in IDLE and on the edge that leaves RUN
  assign w_cmp_en = w_run & bus.i_Enable;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      logic r_pwm;

      // Registered unsigned compare of the live count against this channel's shadow duty
      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          r_pwm <= 1'b0;
        end else begin
          r_pwm <= w_cmp_en & (w_count < w_sh_duty[k*DATA_W +: DATA_W]);
        end
      end

      assign w_pwm[k] = r_pwm;
    end
  endgenerate

  assign bus.o_Pwm        = w_pwm;
  assign bus.o_Period_End = w_period_end;
  assign bus.o_Running    = w_run;

endmodule : pwm_generator
`default_nettype wire
